// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for peripheral_timer.
//   Register byte offsets from the peripheral base, TCON bit indices and the
//   prescaler width. Imported by the top and by timer_prescaler.
package timer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;
  localparam logic [31:0] OFF_PRESC   = 32'h0000_0018;

  localparam int unsigned TCON_EN    = 0;
  localparam int unsigned TCON_IRQEN = 1;
  localparam int unsigned TCON_STAT  = 2;

  localparam int unsigned PRESC_W = 8;

endpackage

// File: rtl/peripheral_timer_if.sv
// peripheral_timer_if: MEM-stage load/store bus seen by peripheral_timer.
//   Address    [31:0] byte address (same bus as data memory)
//   Write_data [31:0] store data
//   MemRead           load strobe
//   MemWrite          store strobe
//   Read_data  [31:0] combinational load data (slave -> master)
//   irq               level timer interrupt (slave -> master)
interface peripheral_timer_if;

  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        irq;

  modport master (
    output Address,
    output Write_data,
    output MemRead,
    output MemWrite,
    input  Read_data,
    input  irq
  );

  modport slave (
    input  Address,
    input  Write_data,
    input  MemRead,
    input  MemWrite,
    output Read_data,
    output irq
  );

endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk into timer ticks. Only built when the macro
// TIMER_PRESCALE_EN is defined; the default build has no prescaler at all.
//   clk    system clock
//   reset  asynchronous active-high reset
//   presc  [7:0] terminal count; tick fires when the counter equals it
//   clr    clears the counter (PRESC register write)
//   tick   one-cycle tick, combinational from the counter state
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // presc == 0 keeps the counter at 0 and ticks every cycle.
  assign tick = (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/peripheral_timer.sv
// peripheral_timer: memory-mapped reload timer plus free-running SYSTICK.
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-high reset
//   bus    peripheral_timer_if.slave (Address, Write_data, MemRead, MemWrite,
//          Read_data, irq)
// Registers (from BASE_ADDR): TH +0x00, TL +0x04, TCON +0x08 ([0] en,
// [1] irq_en, [2] status), SYSTICK +0x14 (RO), PRESC +0x18.
// Optional macro TIMER_PRESCALE_EN adds the PRESC register and prescaler;
// without it the timer ticks every cycle and PRESC reads as zero.
module peripheral_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input logic               clk,
  input logic               reset,
  peripheral_timer_if.slave bus
);

  logic [31:0] th_q, tl_q, tl_d, systick_q;
  logic [2:0]  tcon_q, tcon_d;

  logic sel_th, sel_tl, sel_tcon, sel_systick, sel_presc;
  logic wr_th, wr_tl, wr_tcon;
  logic tick, overflow;
  logic [PRESC_W-1:0] presc_rd;
  logic [31:0] rdata;

  // Exact full-width decode: no aliasing of partial addresses.
  assign sel_th      = (bus.Address == BASE_ADDR + OFF_TH);
  assign sel_tl      = (bus.Address == BASE_ADDR + OFF_TL);
  assign sel_tcon    = (bus.Address == BASE_ADDR + OFF_TCON);
  assign sel_systick = (bus.Address == BASE_ADDR + OFF_SYSTICK);
  assign sel_presc   = (bus.Address == BASE_ADDR + OFF_PRESC);

  assign wr_th   = bus.MemWrite & sel_th;
  assign wr_tl   = bus.MemWrite & sel_tl;
  assign wr_tcon = bus.MemWrite & sel_tcon;

`ifdef TIMER_PRESCALE_EN
  logic               wr_presc;
  logic [PRESC_W-1:0] presc_q;

  assign wr_presc = bus.MemWrite & sel_presc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (wr_presc) begin
      presc_q <= bus.Write_data[PRESC_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .presc (presc_q),
    .clr   (wr_presc),
    .tick  (tick)
  );

  assign presc_rd = presc_q;
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif

  always_comb begin
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    overflow = tick & tcon_q[TCON_EN] & (tl_q == 32'hFFFF_FFFF);

    if (tick && tcon_q[TCON_EN]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end
    // Software write to TL beats the tick in the same cycle.
    if (wr_tl) begin
      tl_d = bus.Write_data;
    end

    if (wr_tcon) begin
      tcon_d[TCON_EN]    = bus.Write_data[TCON_EN];
      tcon_d[TCON_IRQEN] = bus.Write_data[TCON_IRQEN];
      // Status is write-0-to-clear; writing 1 leaves it alone.
      if (!bus.Write_data[TCON_STAT]) begin
        tcon_d[TCON_STAT] = 1'b0;
      end
    end
    // Hardware set is applied last so it wins over a same-cycle clear.
    if (overflow && tcon_q[TCON_IRQEN]) begin
      tcon_d[TCON_STAT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      if (wr_th) begin
        th_q <= bus.Write_data;
      end
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
    end
  end

  // Zero-latency read; reflects pre-write state in a write cycle.
  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      if (sel_th) begin
        rdata = th_q;
      end else if (sel_tl) begin
        rdata = tl_q;
      end else if (sel_tcon) begin
        rdata = {29'd0, tcon_q};
      end else if (sel_systick) begin
        rdata = systick_q;
      end else if (sel_presc) begin
        rdata = {{(32 - PRESC_W){1'b0}}, presc_rd};
      end
    end
  end

  assign bus.Read_data = rdata;
  assign bus.irq       = tcon_q[TCON_IRQEN] & tcon_q[TCON_STAT];

endmodule

// File: tb/tb_peripheral_timer.sv
// Self-checking bench for peripheral_timer: directed vector table plus
// hand-written sequences for reset and prescaler corner cases.
module tb_peripheral_timer;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
  localparam logic [31:0] A_PRESC   = 32'h4000_0018;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] EXP_PRESC = 32'd3;
`else
  localparam logic [31:0] EXP_PRESC = 32'd0;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  localparam int NVEC = 36;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] sys_model;
  vec_t vecs[NVEC];

  peripheral_timer_if bus ();

  peripheral_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference count of clock edges since reset: the expected SYSTICK.
  always @(posedge clk or posedge reset) begin
    if (reset) sys_model <= '0;
    else       sys_model <= sys_model + 32'd1;
  end

  function automatic vec_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] exp_rd, logic exp_irq);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Set bus inputs now and let combinational outputs settle.
  task automatic peek(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wd);
    bus.MemWrite   = we;
    bus.MemRead    = re;
    bus.Address    = addr;
    bus.Write_data = wd;
    #1;
  endtask

  // One bus cycle: drive after the falling edge, takes effect on next rising edge.
  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    peek(we, re, addr, wd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    peek(1'b0, 1'b0, 32'h0, 32'h0);

    vecs[0]  = mk(0, 1, A_TH,         32'h0,         32'h0,         0);
    vecs[1]  = mk(0, 1, A_TL,         32'h0,         32'h0,         0);
    vecs[2]  = mk(0, 1, A_TCON,       32'h0,         32'h0,         0);
    vecs[3]  = mk(0, 1, A_PRESC,      32'h0,         32'h0,         0);
    vecs[4]  = mk(1, 0, A_TH,         32'hFFFF_FFF0, 32'h0,         0);
    vecs[5]  = mk(0, 1, A_TH,         32'h0,         32'hFFFF_FFF0, 0);
    vecs[6]  = mk(1, 0, A_TL,         32'hFFFF_FFFE, 32'h0,         0);
    vecs[7]  = mk(0, 1, A_TL,         32'h0,         32'hFFFF_FFFE, 0);
    vecs[8]  = mk(1, 1, A_TCON,       32'h7,         32'h0,         0); // bit2 write ignored
    vecs[9]  = mk(0, 1, A_TL,         32'h0,         32'hFFFF_FFFE, 0);
    vecs[10] = mk(0, 1, A_TL,         32'h0,         32'hFFFF_FFFF, 0);
    vecs[11] = mk(0, 1, A_TL,         32'h0,         32'hFFFF_FFF0, 1); // reload + irq
    vecs[12] = mk(0, 1, A_TCON,       32'h0,         32'h7,         1);
    vecs[13] = mk(1, 0, A_TCON,       32'h3,         32'h0,         1);
    vecs[14] = mk(0, 1, A_TCON,       32'h0,         32'h3,         0);
    vecs[15] = mk(1, 0, A_TL,         32'hFFFF_FFFF, 32'h0,         0);
    vecs[16] = mk(1, 0, A_TCON,       32'h3,         32'h0,         0); // clear vs overflow
    vecs[17] = mk(0, 1, A_TCON,       32'h0,         32'h7,         1);
    vecs[18] = mk(0, 1, A_TL,         32'h0,         32'hFFFF_FFF1, 1);
    vecs[19] = mk(1, 1, A_TL,         32'h5,         32'hFFFF_FFF2, 1); // read old value
    vecs[20] = mk(0, 1, A_TL,         32'h0,         32'h5,         1);
    vecs[21] = mk(0, 1, A_TL,         32'h0,         32'h6,         1);
    vecs[22] = mk(1, 0, A_TH,         32'h100,       32'h0,         1);
    vecs[23] = mk(0, 1, A_TL,         32'h0,         32'h8,         1);
    vecs[24] = mk(0, 1, 32'h4000_000C, 32'h0,        32'h0,         1);
    vecs[25] = mk(1, 0, 32'h4000_001C, 32'h1234,     32'h0,         1);
    vecs[26] = mk(0, 1, A_TH,         32'h0,         32'h100,       1);
    vecs[27] = mk(0, 1, 32'h4000_0001, 32'h0,        32'h0,         1);
    vecs[28] = mk(0, 1, A_TCON,       32'h0,         32'h7,         1);
    vecs[29] = mk(0, 0, A_TH,         32'h0,         32'h0,         1);
    vecs[30] = mk(1, 0, A_TCON,       32'h0,         32'h0,         1);
    vecs[31] = mk(0, 1, A_TL,         32'h0,         32'h10,        0);
    vecs[32] = mk(0, 1, A_TL,         32'h0,         32'h10,        0); // held when disabled
    vecs[33] = mk(1, 0, A_PRESC,      32'h3,         32'h0,         0);
    vecs[34] = mk(0, 1, A_PRESC,      32'h0,         EXP_PRESC,     0);
    vecs[35] = mk(1, 0, A_SYSTICK,    32'hDEAD_BEEF, 32'h0,         0);

    // Reset state, read while reset is held.
    peek(1'b0, 1'b1, A_TL, 32'h0);
    check("reset TL", bus.Read_data, 32'h0);
    peek(1'b0, 1'b1, A_SYSTICK, 32'h0);
    check("reset SYSTICK", bus.Read_data, 32'h0);
    check("reset irq", {31'd0, bus.irq}, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    peek(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    drive(1'b0, 1'b1, A_SYSTICK, 32'h0);
    check("systick after 10", bus.Read_data, 32'd10);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d rdata", i), bus.Read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
    end

    drive(1'b0, 1'b1, A_SYSTICK, 32'h0);
    check("systick write ignored", bus.Read_data, sys_model);

    // Asynchronous reset in the middle of a count clears everything at once.
    drive(1'b1, 1'b0, A_TCON, 32'h3);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    reset = 1'b1;
    peek(1'b0, 1'b1, A_TH, 32'h0);
    check("midreset TH", bus.Read_data, 32'h0);
    peek(1'b0, 1'b1, A_TL, 32'h0);
    check("midreset TL", bus.Read_data, 32'h0);
    peek(1'b0, 1'b1, A_TCON, 32'h0);
    check("midreset TCON", bus.Read_data, 32'h0);
    peek(1'b0, 1'b1, A_PRESC, 32'h0);
    check("midreset PRESC", bus.Read_data, 32'h0);
    check("midreset irq", {31'd0, bus.irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, A_SYSTICK, 32'h0);
    check("first edge after reset", bus.Read_data, 32'd1);
    drive(1'b0, 1'b1, A_TL, 32'h0);
    check("no residual tick", bus.Read_data, 32'h0);

`ifdef TIMER_PRESCALE_EN
    drive(1'b1, 1'b0, A_PRESC, 32'h3);
    drive(1'b1, 1'b0, A_TCON, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, A_TL, 32'h0);
      check($sformatf("presc TL edge%0d", k), bus.Read_data,
            (k >= 8) ? 32'd2 : ((k >= 4) ? 32'd1 : 32'd0));
    end
    #2;
    reset = 1'b1;
    peek(1'b0, 1'b1, A_PRESC, 32'h0);
    check("presc reset PRESC", bus.Read_data, 32'h0);
    peek(1'b0, 1'b1, A_TL, 32'h0);
    check("presc reset TL", bus.Read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
`endif

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
